// File: rtl/lake_cfg_pkg.sv
// Shared types and helpers for the LakeSpec configuration sequencer.
package lake_cfg_pkg;

  localparam int unsigned CFG_WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StFlush,
    StRun
  } cfg_seq_state_t;

  function automatic int unsigned cfg_num_words(int unsigned w);
    return (w + CFG_WORD_W - 1) / CFG_WORD_W;
  endfunction

endpackage

// File: rtl/lake_cfg_shadow_regs.sv
// Word-addressed shadow copy of the configuration vector with a registered read port.
module lake_cfg_shadow_regs
  import lake_cfg_pkg::*;
#(
  parameter int unsigned CfgWidth = 550
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wr_data_i,
  output logic                addr_ok_o,
  output logic [31:0]         rd_data_o,
  output logic                rd_valid_o,
  output logic [CfgWidth-1:0] shadow_next_o
);

  localparam int unsigned NumWords = cfg_num_words(CfgWidth);
  localparam int unsigned LastBits = CfgWidth - CFG_WORD_W * (NumWords - 1);
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [31:0] LastMask = 32'((64'd1 << LastBits) - 64'd1);

  logic [NumWords*32-1:0] words_q, words_d;
  logic [IdxW-1:0]        idx;
  logic [31:0]            wdata;
  logic [31:0]            rd_data_q, rd_data_d;
  logic                   rd_valid_q;

  assign addr_ok_o = addr_i < 32'(NumWords);
  assign idx       = addr_i[IdxW-1:0];

  always_comb begin
    words_d = words_q;
    wdata   = wr_data_i;
    // Bits above CfgWidth in the last word are never stored.
    if (idx == IdxW'(NumWords - 1)) wdata = wr_data_i & LastMask;
    if (wr_en_i && addr_ok_o) words_d[32*int'(idx) +: 32] = wdata;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = addr_ok_o ? words_q[32*int'(idx) +: 32] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      words_q    <= words_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  // Includes a same-cycle write so a commit captures it.
  assign shadow_next_o = words_d[CfgWidth-1:0];

endmodule

// File: rtl/lake_config_sequencer.sv
// Loads LakeSpec configuration over a 32-bit bus, commits it on start, flushes, then runs.
module lake_config_sequencer
  import lake_cfg_pkg::*;
#(
  parameter int unsigned CFG_WIDTH    = 550,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          config_addr,
  input  logic [31:0]          config_data,
  input  logic                 config_write,
  input  logic                 config_read,
  output logic [31:0]          config_rd_data,
  output logic                 config_rd_valid,
  input  logic                 start,
  input  logic                 halt,
  output logic [CFG_WIDTH-1:0] cfg_out,
  output logic                 flush_out,
  output logic                 running,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(FLUSH_CYCLES - 1);

  cfg_seq_state_t       state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 flush_q, flush_d;
  logic                 running_q, running_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [CFG_WIDTH-1:0] cfg_q;
  logic [CFG_WIDTH-1:0] shadow_next;
  logic                 bus_open, commit, wr_en, addr_ok;

  assign bus_open = (state_q == StIdle) || (state_q == StRun);
  assign commit   = start && !halt && bus_open;
  assign wr_en    = config_write && bus_open;

  lake_cfg_shadow_regs #(
    .CfgWidth (CFG_WIDTH)
  ) u_shadow (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wr_en_i       (wr_en),
    .rd_en_i       (config_read),
    .addr_i        (config_addr),
    .wr_data_i     (config_data),
    .addr_ok_o     (addr_ok),
    .rd_data_o     (config_rd_data),
    .rd_valid_o    (config_rd_valid),
    .shadow_next_o (shadow_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (halt) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StRun: if (start) state_d = StApply;
        StApply: begin
          state_d = StFlush;
          cnt_d   = CntLoad;
        end
        StFlush: begin
          if (cnt_q == '0) state_d = StRun;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Status outputs are registered from the next state so they never glitch.
  always_comb begin
    flush_d   = (state_d == StFlush);
    running_d = (state_d == StRun);
    busy_d    = (state_d == StApply) || (state_d == StFlush);
    err_d     = commit ? 1'b0 : err_q;
    if (config_write && (!bus_open || !addr_ok)) err_d = 1'b1;
    if (config_read && !addr_ok)                 err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      running_q <= running_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      if (commit) cfg_q <= shadow_next;
    end
  end

  assign cfg_out   = cfg_q;
  assign flush_out = flush_q;
  assign running   = running_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lake_config_sequencer.sv
// Scoreboard bench: timing-based reference model plus a decoupled readback monitor.
module tb_lake_config_sequencer;

  localparam int CW = 550;
  localparam int FC = 4;
  localparam int NW = (CW + 31) / 32;
  localparam int LASTB = CW - 32 * (NW - 1);

  logic          clk, rst_n;
  logic [31:0]   config_addr, config_data, config_rd_data;
  logic          config_write, config_read, config_rd_valid;
  logic          start, halt;
  logic [CW-1:0] cfg_out;
  logic          flush_out, running, busy, err;

  lake_config_sequencer #(
    .CFG_WIDTH    (CW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .config_addr     (config_addr),
    .config_data     (config_data),
    .config_write    (config_write),
    .config_read     (config_read),
    .config_rd_data  (config_rd_data),
    .config_rd_valid (config_rd_valid),
    .start           (start),
    .halt            (halt),
    .cfg_out         (cfg_out),
    .flush_out       (flush_out),
    .running         (running),
    .busy            (busy),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  // Model: shadow/active words, sticky err, and the cycle a commit landed (-1 = idle).
  logic [31:0] m_shadow[NW];
  logic [31:0] m_active[NW];
  logic        m_err;
  int          m_commit;
  int          cyc;
  rd_exp_t     rdq[$];
  int          n_cmp, n_fail;

  function automatic logic [31:0] wmask(int a);
    logic [63:0] m;
    m = (64'd1 << LASTB) - 64'd1;
    return (a == NW - 1) ? m[31:0] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [CW-1:0] flat_active();
    logic [NW*32-1:0] f;
    for (int i = 0; i < NW; i++) f[i*32 +: 32] = m_active[i];
    return f[CW-1:0];
  endfunction

  function automatic bit exp_busy(int c);
    return m_commit >= 0 && c >= m_commit && c <= m_commit + FC;
  endfunction

  function automatic bit exp_flush(int c);
    return m_commit >= 0 && c >= m_commit + 1 && c <= m_commit + FC;
  endfunction

  function automatic bit exp_running(int c);
    return m_commit >= 0 && c >= m_commit + FC + 1;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_err    = 1'b0;
    m_commit = -1;
    rdq.delete();
  endtask

  task automatic cycle(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] data, input bit st, input bit hl);
    logic [31:0] sh_n[NW];
    bit          busy_now, start_ok;
    logic        err_n;
    int          commit_n;
    rd_exp_t     e;
    config_write = wr;
    config_read  = rd;
    config_addr  = addr;
    config_data  = data;
    start        = st;
    halt         = hl;
    busy_now = exp_busy(cyc);
    start_ok = st && !hl && !busy_now;
    sh_n     = m_shadow;
    err_n    = start_ok ? 1'b0 : m_err;
    commit_n = m_commit;
    if (wr) begin
      if (busy_now || addr >= NW) err_n = 1'b1;
      else sh_n[addr] = data & wmask(int'(addr));
    end
    if (rd) begin
      e.data = '0;
      if (addr < NW) e.data = m_shadow[addr];
      else err_n = 1'b1;
      e.due = cyc + 1;
      rdq.push_back(e);
    end
    if (hl) commit_n = -1;
    else if (start_ok) commit_n = cyc + 1;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      m_shadow = sh_n;
      m_err    = err_n;
      m_commit = commit_n;
      if (start_ok) m_active = sh_n;
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 32'd0, 0, 0);
  endtask

  always @(negedge clk) begin
    chk("flush_out", CW'(flush_out), CW'(exp_flush(cyc)));
    chk("running", CW'(running), CW'(exp_running(cyc)));
    chk("busy", CW'(busy), CW'(exp_busy(cyc)));
    chk("err", CW'(err), CW'(m_err));
    chk("cfg_out", cfg_out, flat_active());
    if (config_rd_valid) begin
      if (rdq.size() == 0 || rdq[0].due != cyc) begin
        chk("rd_valid_unexpected", CW'(1), CW'(0));
      end else begin
        rd_exp_t e;
        e = rdq.pop_front();
        chk("rd_data", CW'(config_rd_data), CW'(e.data));
      end
    end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
      void'(rdq.pop_front());
      chk("rd_valid_missing", CW'(0), CW'(1));
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    model_reset();
    rst_n = 1'b0;
    config_write = 0; config_read = 0; config_addr = '0; config_data = '0;
    start = 0; halt = 0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < NW; i++) cycle(1, 0, 32'(i), 32'hA5A5_0000 + 32'(i), 0, 0);
    for (int i = 0; i < NW; i++) cycle(0, 1, 32'(i), 32'd0, 0, 0);
    idle(2);
    cycle(0, 0, 32'd0, 32'd0, 1, 0);
    idle(8);

    // Bad address, then a write dropped during flush; next start clears err.
    cycle(1, 0, 32'd18, 32'hFFFF_FFFF, 0, 0);
    cycle(0, 1, 32'd18, 32'd0, 0, 0);
    idle(1);
    cycle(0, 0, 32'd0, 32'd0, 1, 0);
    idle(1);
    cycle(1, 0, 32'd0, 32'hDEAD_BEEF, 0, 0);
    idle(6);
    cycle(0, 1, 32'd0, 32'd0, 0, 0);
    cycle(0, 0, 32'd0, 32'd0, 1, 0);
    idle(7);

    // Halt on the second flush cycle, then a clean restart.
    cycle(0, 0, 32'd0, 32'd0, 1, 0);
    idle(2);
    cycle(0, 0, 32'd0, 32'd0, 0, 1);
    idle(2);
    cycle(0, 0, 32'd0, 32'd0, 1, 0);
    idle(7);

    // Rewrite in RUN leaves cfg_out alone until the next start.
    cycle(1, 0, 32'd0, 32'h0000_1234, 0, 0);
    idle(2);
    cycle(0, 0, 32'd0, 32'd0, 1, 0);
    idle(7);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) == 0, ($urandom % 4) == 0, 32'($urandom_range(0, 19)), $urandom,
            ($urandom % 16) == 0, ($urandom % 32) == 0);
    end
    idle(FC + 3);

    // Asynchronous reset in the middle of a flush.
    cycle(1, 0, 32'd3, 32'h0BAD_F00D, 1, 0);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("async_flush_out", CW'(flush_out), CW'(0));
    chk("async_running", CW'(running), CW'(0));
    chk("async_busy", CW'(busy), CW'(0));
    chk("async_cfg_out", cfg_out, CW'(0));
    chk("async_rd_valid", CW'(config_rd_valid), CW'(0));
    model_reset();
    idle(3);
    rst_n = 1'b1;
    cycle(0, 1, 32'd3, 32'd0, 0, 0);
    idle(3);
    chk("rd_queue_drained", CW'(rdq.size()), CW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
